// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator: two row delay lines plus a column shift window,
// emitting only neighbourhoods that lie fully inside the image.
module conv_window_3x3 #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [9*WIDTH-1:0]         window_o,
  output logic                       valid_o,
  output logic                       frame_done_o,
  output logic [$clog2(IMG_W)-1:0]   col_o,
  output logic [$clog2(IMG_H)-1:0]   row_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

  logic [WIDTH-1:0]   lb1_q [IMG_W];
  logic [WIDTH-1:0]   lb1_d [IMG_W];
  logic [WIDTH-1:0]   lb2_q [IMG_W];
  logic [WIDTH-1:0]   lb2_d [IMG_W];
  logic [3*WIDTH-1:0] col0_q, col0_d;
  logic [3*WIDTH-1:0] col1_q, col1_d;
  logic [3*WIDTH-1:0] new_col;
  logic [9*WIDTH-1:0] window_q, window_d;
  logic               valid_q, valid_d;
  logic               frame_done_q, frame_done_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               emit;

  always_comb begin
    lb1_d        = lb1_q;
    lb2_d        = lb2_q;
    col0_d       = col0_q;
    col1_d       = col1_q;
    window_d     = window_q;
    col_d        = col_q;
    row_d        = row_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    // Newest column, top row (oldest line) in the low slot.
    new_col      = {data_i, lb1_q[IMG_W-1], lb2_q[IMG_W-1]};
    emit         = valid_i && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);

    if (valid_i) begin
      lb1_d[0] = data_i;
      lb2_d[0] = lb1_q[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb1_d[i] = lb1_q[i-1];
        lb2_d[i] = lb2_q[i-1];
      end
      col0_d = col1_q;
      col1_d = new_col;

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // Output window only updates on emission so it holds between windows.
    if (emit) begin
      for (int r = 0; r < 3; r++) begin
        window_d[(3*r+0)*WIDTH +: WIDTH] = col0_q[r*WIDTH +: WIDTH];
        window_d[(3*r+1)*WIDTH +: WIDTH] = col1_q[r*WIDTH +: WIDTH];
        window_d[(3*r+2)*WIDTH +: WIDTH] = new_col[r*WIDTH +: WIDTH];
      end
      valid_d      = 1'b1;
      frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb1_q        <= '{default: '0};
      lb2_q        <= '{default: '0};
      col0_q       <= '0;
      col1_q       <= '0;
      window_q     <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      lb1_q        <= lb1_d;
      lb2_q        <= lb2_d;
      col0_q       <= col0_d;
      col1_q       <= col1_d;
      window_q     <= window_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  assign window_o     = window_q;
  assign valid_o      = valid_q;
  assign frame_done_o = frame_done_q;
  assign col_o        = col_q;
  assign row_o        = row_q;

endmodule
